poly_operand_sel: RTL and testbench
===================================

# poly_operand_sel

Parametrised, registered N-to-1 polynomial operand selector that feeds the CLA adder datapath. It picks one of `NUM_IN` packed polynomials per transaction and holds it in an output register behind a valid/ready handshake. Out-of-range selects are flagged rather than producing undefined data. An optional auto-sequence mode streams sources 0..len-1 back-to-back without per-beat requests. It sits between the polynomial storage/NTT outputs and the adder input port.

## Interface
- `NUM_IN`, default 5: number of polynomial sources, ≥2.
- `N_COEFF`, default `KYBER_N`: coefficients per polynomial.
- `COEF_W`, default 12: bits per coefficient.
- Derived: `POLY_W = N_COEFF*COEF_W`, `SEL_W = max(1, $clog2(NUM_IN))`, `LEN_W = $clog2(NUM_IN+1)`.

- `clk  in  1`: single clock. All logic is on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `in_data  in  NUM_IN*POLY_W`: source i occupies bits `[i*POLY_W +: POLY_W]`.
- `req_sel  in  SEL_W`: source index for a manual request.
- `req_valid  in  1`: manual request present.
- `req_ready  out  1`: manual request accepted this cycle when high together with `req_valid`.
- `seq_start  in  1`: auto-sequence start pulse (exists only with macro).
- `seq_len  in  LEN_W`: number of sources to stream (exists only with macro).
- `seq_busy  out  1`: sequence in progress (exists only with macro).
- `seq_done  out  1`: one-cycle pulse (exists only with macro).
- `out_data  out  POLY_W`: selected polynomial.
- `out_src  out  SEL_W`: index that produced `out_data`.
- `out_err  out  1`: beat came from an out-of-range index.
- `out_valid  out  1`: output register holds a beat.
- `out_ready  in  1`: downstream accepts the beat.

## Operation
- One-entry output register. It loads when `load = !out_valid || out_ready`, i.e. it can accept a new beat every cycle under continuous `out_ready`.
- Manual mode (state IDLE):
  - `req_ready = load && !seq_start`.
  - On `req_valid && req_ready`, the register loads `in_data` slice `req_sel`, `out_src = req_sel`, `out_err = 0`, and `out_valid = 1`.
- Out of range (`req_sel ≥ NUM_IN`): the beat is still issued, with `out_data = 0`, `out_src = req_sel`, `out_err = 1`. The request is never stalled or dropped.
- Without a new load, `out_valid` clears when `out_ready` is high.
- `out_data`, `out_src` and `out_err` stay stable while `out_valid && !out_ready`.
- Auto-sequence (macro on), states IDLE → SEQ:
  - `seq_start` in IDLE latches `eff_len = min(seq_len, NUM_IN)` and clears index `k`.
  - If `eff_len == 0`: stay in IDLE and pulse `seq_done` next cycle.
  - Otherwise go to SEQ with `seq_busy = 1`.
  - In SEQ, on each `load`, the register takes source `k` (`out_err = 0`) and `k` increments. `req_ready = 0` throughout SEQ.
  - When the beat for `k = eff_len-1` loads, `seq_done` pulses in that same cycle and the state returns to IDLE next cycle.
  - `seq_start` while in SEQ is ignored.
- Simultaneous `seq_start` and `req_valid` in IDLE: the sequence wins and the request is not accepted.
- Reset mid-operation aborts any sequence and discards the held beat.

## Timing
- Latency: 1 cycle from accepted request (or sequence step) to `out_valid`.
- Throughput: 1 beat/cycle under continuous `out_ready`.
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_src=0`, `out_err=0`.
  - `seq_busy=0`, `seq_done=0`, state IDLE, `k=0`.
  - `req_ready` is high in the first cycle after reset, since it is derived from `load`.
- `req_ready` combinationally depends on `out_ready`, `out_valid`, state and `seq_start`. There is no other combinational input-to-output path.
- A sequence of length L with `out_ready` held high: beats occur on cycles 1..L after the `seq_start` cycle, `seq_done` in cycle L, `seq_busy` low from cycle L+1.

## Configuration
- `OPSEL_AUTOSEQ_EN` defined: SEQ state, `seq_*` ports and the step counter are compiled in.
- Not defined: the `seq_*` ports are absent, the block is manual-only, and `req_ready = load`.

## Structure
- Shared package `opsel_pkg`:
  - state enum `opsel_state_e {IDLE, SEQ}`.
  - `sel_width(n)` function.
  - `KYBER_N`-based `POLY_W` localparam default.
- Sub-module `poly_mux_n`: purely combinational N:1 slice selector with an in-range flag. Zero output when out of range.
- The top level holds the FSM, counter and output register.

## Test plan
- Manual select, all sources:
  - Stimulus: `NUM_IN=5`, `in_data` slice i = all coefficients 12'h100+i; requests sel 0..4 with `out_ready=1`.
  - Required response: 5 consecutive beats with coefficients 12'h100..12'h104, `out_src` 0..4, `out_err=0`.
- Backpressure:
  - Stimulus: sel=3 with `out_ready=0` for 4 cycles, then `req_valid` held with sel=1.
  - Required response: `req_ready=0` while stalled, beat 3 stays stable; once `out_ready=1`, beat 1 follows on the next cycle.
- Out-of-range:
  - Stimulus: sel=6.
  - Required response: one beat with `out_data=0`, `out_src=6`, `out_err=1`; the following sel=2 beat has `out_err=0`.
- Auto-sequence:
  - Stimulus: `seq_len=3`, `seq_start` pulsed, `out_ready` toggling 1,0,1,1.
  - Required response: beats src 0,1,2 in order, `seq_done` on the src-2 load, `req_valid` ignored during SEQ.
- Length edge cases:
  - Stimulus: `seq_len=0`, then `seq_len=7`.
  - Required response: for 0, `seq_done` the next cycle with no beats; for 7, exactly 5 beats.
  - Stimulus: `seq_start` together with `req_valid`.
  - Required response: the request is not accepted.
- Reset mid-sequence:
  - Stimulus: `rst` asserted after 2 of 5 beats.
  - Required response: all outputs at reset values the next cycle; a new sequence restarts at src 0.

Source files
------------

// File: rtl/opsel_pkg.sv
// Shared types and helpers for the polynomial operand selector.
package opsel_pkg;

    localparam int KYBER_N      = 256;
    localparam int KYBER_COEF_W = 12;
    localparam int DEF_POLY_W   = KYBER_N * KYBER_COEF_W;

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } opsel_state_e;

    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/poly_mux_n.sv
// Combinational N:1 polynomial slice selector; zero data and hit=0 for indices outside 0..NUM_IN-1.
module poly_mux_n #(
    parameter int NUM_IN = 5,
    parameter int POLY_W = 48,
    parameter int SEL_W  = 3
) (
    input  logic [NUM_IN*POLY_W-1:0] in_data,
    input  logic [SEL_W-1:0]         sel,
    output logic [POLY_W-1:0]        data,
    output logic                     hit
);

    always_comb begin
        data = '0;
        hit  = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                data = in_data[i*POLY_W +: POLY_W];
                hit  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/poly_operand_sel.sv
// Registered N:1 polynomial operand selector with valid/ready output.
// Define OPSEL_AUTOSEQ_EN to compile in the auto-sequence mode (seq_* ports).
module poly_operand_sel
    import opsel_pkg::*;
#(
    parameter int NUM_IN  = 5,
    parameter int N_COEFF = KYBER_N,
    parameter int COEF_W  = 12,
    localparam int POLY_W = N_COEFF * COEF_W,
    localparam int SEL_W  = sel_width(NUM_IN),
    localparam int LEN_W  = $clog2(NUM_IN + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN*POLY_W-1:0] in_data,
    input  logic [SEL_W-1:0]         req_sel,
    input  logic                     req_valid,
    output logic                     req_ready,
`ifdef OPSEL_AUTOSEQ_EN
    input  logic                     seq_start,
    input  logic [LEN_W-1:0]         seq_len,
    output logic                     seq_busy,
    output logic                     seq_done,
`endif
    output logic [POLY_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_src,
    output logic                     out_err,
    output logic                     out_valid,
    input  logic                     out_ready
);

    logic              load;
    logic              take;
    logic [SEL_W-1:0]  mux_sel;
    logic [POLY_W-1:0] mux_data;
    logic              mux_hit;

    logic [POLY_W-1:0] data_p1;
    logic [SEL_W-1:0]  src_p1;
    logic              err_p1;
    logic              vld_p1;

    assign load = !vld_p1 || out_ready;

`ifdef OPSEL_AUTOSEQ_EN
    opsel_state_e     state_q, state_d;
    logic [SEL_W-1:0] k_q;
    logic [LEN_W-1:0] eff_len_q;
    logic [LEN_W-1:0] eff_len_in;
    logic             zero_done_q;
    logic             seq_step;
    logic             seq_last;

    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(NUM_IN)) ? LEN_W'(NUM_IN) : len;
    endfunction

    assign eff_len_in = sat_len(seq_len);
    assign seq_step   = (state_q == SEQ) && load;
    assign seq_last   = (LEN_W'(k_q) + LEN_W'(1)) == eff_len_q;
    assign req_ready  = load && !seq_start && (state_q == IDLE);
    assign mux_sel    = (state_q == SEQ) ? k_q : req_sel;
    assign take       = seq_step || (req_valid && req_ready);
    assign seq_busy   = (state_q == SEQ);
    // Done fires on the load of the last beat, or one cycle after a zero-length start.
    assign seq_done   = zero_done_q || (seq_step && seq_last);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (seq_start && (eff_len_in != '0)) state_d = SEQ;
            SEQ:  if (seq_step && seq_last) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            eff_len_q   <= '0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            zero_done_q <= (state_q == IDLE) && seq_start && (eff_len_in == '0);
            if ((state_q == IDLE) && seq_start) begin
                eff_len_q <= eff_len_in;
                k_q       <= '0;
            end else if (seq_step) begin
                k_q <= k_q + SEL_W'(1);
            end
        end
    end
`else
    assign req_ready = load;
    assign mux_sel   = req_sel;
    assign take      = req_valid && req_ready;
`endif

    poly_mux_n #(
        .NUM_IN (NUM_IN),
        .POLY_W (POLY_W),
        .SEL_W  (SEL_W)
    ) u_mux (
        .in_data (in_data),
        .sel     (mux_sel),
        .data    (mux_data),
        .hit     (mux_hit)
    );

    // Stage p1: one-entry output register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            src_p1  <= '0;
            err_p1  <= 1'b0;
        end else if (take) begin
            vld_p1  <= 1'b1;
            data_p1 <= mux_data;
            src_p1  <= mux_sel;
            err_p1  <= !mux_hit;
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_data  = data_p1;
    assign out_src   = src_p1;
    assign out_err   = err_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_poly_operand_sel.sv
// Randomised self-checking bench for poly_operand_sel against a queue-based reference model.
// Auto-sequence scenarios run when OPSEL_AUTOSEQ_EN is defined.
module tb_poly_operand_sel;

    localparam int NUM_IN  = 5;
    localparam int N_COEFF = 4;
    localparam int COEF_W  = 12;
    localparam int POLY_W  = N_COEFF * COEF_W;
    localparam int SEL_W   = 3;
    localparam int LEN_W   = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_IN*POLY_W-1:0] in_data;
    logic [SEL_W-1:0]         req_sel;
    logic                     req_valid;
    logic                     req_ready;
    logic                     seq_start;
    logic [LEN_W-1:0]         seq_len;
`ifdef OPSEL_AUTOSEQ_EN
    logic                     seq_busy;
    logic                     seq_done;
`endif
    logic [POLY_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_src;
    logic                     out_err;
    logic                     out_valid;
    logic                     out_ready;

    int errs   = 0;
    int checks = 0;

    // Reference model: held beat plus the list of sources still owed by a sequence.
    logic              m_valid;
    logic [POLY_W-1:0] m_data;
    int                m_src;
    logic              m_err;
    logic              m_done_next;
    int                pend[$];

    always #5 clk = ~clk;

    poly_operand_sel #(
        .NUM_IN  (NUM_IN),
        .N_COEFF (N_COEFF),
        .COEF_W  (COEF_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .req_sel   (req_sel),
        .req_valid (req_valid),
        .req_ready (req_ready),
`ifdef OPSEL_AUTOSEQ_EN
        .seq_start (seq_start),
        .seq_len   (seq_len),
        .seq_busy  (seq_busy),
        .seq_done  (seq_done),
`endif
        .out_data  (out_data),
        .out_src   (out_src),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [POLY_W-1:0] src_poly(input int s);
        return in_data[s*POLY_W +: POLY_W];
    endfunction

    task automatic model_reset();
        m_valid     = 1'b0;
        m_data      = '0;
        m_src       = 0;
        m_err       = 1'b0;
        m_done_next = 1'b0;
        pend.delete();
    endtask

    // One clock: check combinational outputs before the edge, advance model, check registers after.
    task automatic step();
        logic ld;
        logic beat;
        logic nd;
        int   s;
        int   eff;
        ld = !m_valid || out_ready;
        #1;
        if (!rst) begin
            check("req_ready", req_ready, ld && !seq_start && (pend.size() == 0));
`ifdef OPSEL_AUTOSEQ_EN
            check("seq_busy", seq_busy, pend.size() != 0);
            check("seq_done", seq_done, m_done_next || (pend.size() == 1 && ld));
`endif
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            beat = 1'b0;
            nd   = 1'b0;
            s    = 0;
            if (pend.size() != 0) begin
                if (ld) begin
                    s    = pend.pop_front();
                    beat = 1'b1;
                end
            end else if (seq_start) begin
                eff = (int'(seq_len) > NUM_IN) ? NUM_IN : int'(seq_len);
                if (eff == 0) nd = 1'b1;
                for (int i = 0; i < eff; i++) pend.push_back(i);
            end else if (req_valid && ld) begin
                s    = int'(req_sel);
                beat = 1'b1;
            end
            m_done_next = nd;
            if (beat) begin
                m_valid = 1'b1;
                m_src   = s;
                if (s < NUM_IN) begin
                    m_err  = 1'b0;
                    m_data = src_poly(s);
                end else begin
                    m_err  = 1'b1;
                    m_data = '0;
                end
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
        #1;
        check("out_valid", out_valid, m_valid);
        if (m_valid || rst) begin
            check("out_data", out_data, m_data);
            check("out_src", out_src, m_src);
            check("out_err", out_err, m_err);
        end
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0;
        req_sel   = '0;
        seq_start = 1'b0;
        seq_len   = '0;
        out_ready = 1'b1;
        rst       = 1'b0;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        in_data = '0;
        rst     = 1'b1;
        step();
        step();
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 64'h0);
        check("rst_src", out_src, 64'h0);
        check("rst_err", out_err, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < NUM_IN; i++)
            for (int c = 0; c < N_COEFF; c++)
                in_data[i*POLY_W + c*COEF_W +: COEF_W] = COEF_W'(12'h100 + i);

        for (int i = 0; i < NUM_IN; i++) begin
            req_valid = 1'b1;
            req_sel   = SEL_W'(i);
            step();
            check("man_coef_lo", out_data[11:0], 12'h100 + i);
            check("man_coef_hi", out_data[47:36], 12'h100 + i);
            check("man_src", out_src, i);
        end
        req_valid = 1'b0;
        step();

        req_valid = 1'b1;
        req_sel   = 3'd3;
        step();
        out_ready = 1'b0;
        req_sel   = 3'd1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_hold_src", out_src, 3);
        end
        out_ready = 1'b1;
        step();
        check("bp_next_src", out_src, 1);
        req_valid = 1'b0;
        step();

        req_valid = 1'b1;
        req_sel   = 3'd6;
        step();
        check("oor_err", out_err, 1'b1);
        check("oor_src", out_src, 6);
        check("oor_data", out_data, 64'h0);
        req_sel = 3'd2;
        step();
        check("oor_next_err", out_err, 1'b0);
        req_valid = 1'b0;
        step();

`ifdef OPSEL_AUTOSEQ_EN
        seq_len   = 3'd3;
        seq_start = 1'b1;
        req_valid = 1'b1;
        req_sel   = 3'd4;
        step();
        seq_start = 1'b0;
        foreach (pend[i]) begin end
        out_ready = 1'b1; step();
        out_ready = 1'b0; step();
        out_ready = 1'b1; step();
        out_ready = 1'b1; step();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();

        seq_len   = 3'd0;
        seq_start = 1'b1;
        step();
        seq_start = 1'b0;
        step();
        step();
        seq_len   = 3'd7;
        seq_start = 1'b1;
        step();
        seq_start = 1'b0;
        for (int i = 0; i < 7; i++) step();

        seq_len   = 3'd5;
        seq_start = 1'b1;
        step();
        seq_start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        seq_start = 1'b1;
        step();
        seq_start = 1'b0;
        step();
        check("restart_src", out_src, 0);
        for (int i = 0; i < 6; i++) step();
`endif

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(15) == 0)
                for (int c = 0; c < NUM_IN*N_COEFF; c++)
                    in_data[c*COEF_W +: COEF_W] = COEF_W'($urandom);
            req_valid = 1'($urandom_range(1));
            req_sel   = SEL_W'($urandom_range(7));
            out_ready = ($urandom_range(3) != 0);
            seq_len   = LEN_W'($urandom_range(7));
`ifdef OPSEL_AUTOSEQ_EN
            seq_start = ($urandom_range(7) == 0);
`else
            seq_start = 1'b0;
`endif
            rst       = ($urandom_range(49) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
